// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event pulses into ON_CYCLES-high / GAP_CYCLES-low pulses,
// queueing events that arrive mid-pulse in a saturating pending counter.
module pulse_stretcher #(
  parameter int ON_CYCLES  = 4095,
  parameter int GAP_CYCLES = 4095,
  parameter int CNT_W      = 12,
  parameter int PEND_W     = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              trigger,
  input  logic              enable,
  output logic              led,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow,
  output logic              done,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [PEND_W-1:0] pending_nx;
  logic              overflow_nx;
  logic              done_nx;
  logic              gap_end;
  logic              start;

  assign state_dbg = state;

  // A new pulse may start from IDLE or straight out of the last GAP cycle,
  // so back-to-back replays never pass through IDLE.
  assign gap_end = (state == GAP) && (cnt == '0);
  assign start   = ((state == IDLE) || gap_end) && enable &&
                   (trigger || (pending != '0));

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    pending_nx  = pending;
    overflow_nx = overflow;
    done_nx     = 1'b0;

    case (state)
      ON: begin
        if (cnt == '0) begin
          state_nx = GAP;
          cnt_nx   = GAP_LOAD;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt != '0) cnt_nx = cnt - CNT_W'(1);
      end
      default: ;
    endcase

    if (gap_end) begin
      done_nx  = 1'b1;
      state_nx = IDLE;
    end

    // A start consumes either the live trigger or one queued event; when both
    // are present the increment and decrement cancel.
    if (start) begin
      state_nx = ON;
      cnt_nx   = ON_LOAD;
      if (!trigger) pending_nx = pending - PEND_W'(1);
    end else if (trigger) begin
      if (pending == PEND_MAX) overflow_nx = 1'b1;
      else                     pending_nx  = pending + PEND_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      pending  <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
      led      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      pending  <= pending_nx;
      overflow <= overflow_nx;
      done     <= done_nx;
      led      <= (state_nx == ON);
      busy     <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher with ON=4, GAP=3, PEND_W=2: per-cycle expected
// {overflow, led, busy, done, pending} words are queued and popped each cycle.
module tb_pulse_stretcher;

  localparam int ON_CYCLES  = 4;
  localparam int GAP_CYCLES = 3;
  localparam int CNT_W      = 4;
  localparam int PEND_W     = 2;

  logic              clock;
  logic              reset;
  logic              trigger;
  logic              enable;
  logic              led;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;
  logic              done;
  logic [1:0]        state_dbg;

  logic [5:0] exp_q[$];
  logic       trig_q[$];
  logic       en_q[$];
  logic [5:0] got;
  logic [5:0] exp;
  int         checks;
  int         passed;
  int         n;

  pulse_stretcher #(
    .ON_CYCLES (ON_CYCLES),
    .GAP_CYCLES(GAP_CYCLES),
    .CNT_W     (CNT_W),
    .PEND_W    (PEND_W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .trigger  (trigger),
    .enable   (enable),
    .led      (led),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow),
    .done     (done),
    .state_dbg(state_dbg)
  );

  // Clock and watchdog
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic tick(input logic t, input logic e);
    trigger = t;
    enable  = e;
    @(posedge clock);
    #1;
    trigger = 1'b0;
  endtask

  function automatic logic [5:0] ev(input logic o, input logic l, input logic b,
                                    input logic d, input logic [1:0] p);
    return {o, l, b, d, p};
  endfunction

  // One full event: ON_CYCLES high then GAP_CYCLES low, pending constant.
  task automatic push_pulse(input logic first_done, input logic [1:0] p, input logic o);
    for (int i = 0; i < ON_CYCLES; i++)
      exp_q.push_back(ev(o, 1'b1, 1'b1, (i == 0) ? first_done : 1'b0, p));
    for (int i = 0; i < GAP_CYCLES; i++)
      exp_q.push_back(ev(o, 1'b0, 1'b1, 1'b0, p));
  endtask

  // Scenarios
  task automatic test_reset();
    reset   = 1'b1;
    trigger = 1'b0;
    enable  = 1'b1;
    #2;
    got = {overflow, led, busy, done, pending};
    checks++;
    if (got !== 6'b0) $display("FAIL reset_async: got %b expected %b", got, 6'b0);
    else passed++;
    repeat (3) @(posedge clock);
    #1;
    trigger = 1'b1;
    @(posedge clock);
    #1;
    trigger = 1'b0;
    got = {overflow, led, busy, done, pending};
    checks++;
    if (got !== 6'b0) $display("FAIL reset_held: got %b expected %b", got, 6'b0);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_single_event();
    push_pulse(1'b0, 2'd0, 1'b0);
    exp_q.push_back(ev(0, 0, 0, 1, 0));
    exp_q.push_back(ev(0, 0, 0, 0, 0));
    for (int i = 0; i < exp_q.size(); i++) begin
      trig_q.push_back(i == 0);
      en_q.push_back(1'b1);
    end
    n = 0;
    while (exp_q.size() > 0) begin
      tick(trig_q.pop_front(), en_q.pop_front());
      exp = exp_q.pop_front();
      got = {overflow, led, busy, done, pending};
      checks++;
      if (got !== exp) $display("FAIL single_event cyc %0d: got %b expected %b", n, got, exp);
      else passed++;
      n++;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < ON_CYCLES; i++) exp_q.push_back(ev(0, 1, 1, 0, 2'(i)));
    for (int i = 0; i < GAP_CYCLES; i++) exp_q.push_back(ev(0, 0, 1, 0, 3));
    push_pulse(1'b1, 2'd2, 1'b0);
    push_pulse(1'b1, 2'd1, 1'b0);
    push_pulse(1'b1, 2'd0, 1'b0);
    exp_q.push_back(ev(0, 0, 0, 1, 0));
    exp_q.push_back(ev(0, 0, 0, 0, 0));
    for (int i = 0; i < exp_q.size(); i++) begin
      trig_q.push_back(i <= 3);
      en_q.push_back(1'b1);
    end
    n = 0;
    while (exp_q.size() > 0) begin
      tick(trig_q.pop_front(), en_q.pop_front());
      exp = exp_q.pop_front();
      got = {overflow, led, busy, done, pending};
      checks++;
      if (got !== exp) $display("FAIL back_to_back cyc %0d: got %b expected %b", n, got, exp);
      else passed++;
      n++;
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < ON_CYCLES; i++) exp_q.push_back(ev(0, 1, 1, 0, 2'(i)));
    for (int i = 0; i < GAP_CYCLES; i++) exp_q.push_back(ev(1, 0, 1, 0, 3));
    push_pulse(1'b1, 2'd2, 1'b1);
    push_pulse(1'b1, 2'd1, 1'b1);
    push_pulse(1'b1, 2'd0, 1'b1);
    exp_q.push_back(ev(1, 0, 0, 1, 0));
    exp_q.push_back(ev(1, 0, 0, 0, 0));
    for (int i = 0; i < exp_q.size(); i++) begin
      trig_q.push_back(i <= 5);
      en_q.push_back(1'b1);
    end
    n = 0;
    while (exp_q.size() > 0) begin
      tick(trig_q.pop_front(), en_q.pop_front());
      exp = exp_q.pop_front();
      got = {overflow, led, busy, done, pending};
      checks++;
      if (got !== exp) $display("FAIL saturation cyc %0d: got %b expected %b", n, got, exp);
      else passed++;
      n++;
    end
    #2 reset = 1'b1;
    #1;
    got = {overflow, led, busy, done, pending};
    checks++;
    if (got !== 6'b0) $display("FAIL overflow_reset: got %b expected %b", got, 6'b0);
    else passed++;
    #2 reset = 1'b0;
  endtask

  task automatic test_enable_gating();
    exp_q.push_back(ev(0, 0, 0, 0, 1));
    exp_q.push_back(ev(0, 0, 0, 0, 1));
    push_pulse(1'b0, 2'd0, 1'b0);
    exp_q.push_back(ev(0, 0, 0, 1, 0));
    exp_q.push_back(ev(0, 0, 0, 0, 0));
    for (int i = 0; i < exp_q.size(); i++) begin
      trig_q.push_back(i == 0);
      en_q.push_back(i >= 2);
    end
    n = 0;
    while (exp_q.size() > 0) begin
      tick(trig_q.pop_front(), en_q.pop_front());
      exp = exp_q.pop_front();
      got = {overflow, led, busy, done, pending};
      checks++;
      if (got !== exp) $display("FAIL enable_gating cyc %0d: got %b expected %b", n, got, exp);
      else passed++;
      n++;
    end
  endtask

  task automatic test_enable_drop();
    exp_q.push_back(ev(0, 1, 1, 0, 0));
    for (int i = 1; i < ON_CYCLES; i++) exp_q.push_back(ev(0, 1, 1, 0, 1));
    for (int i = 0; i < GAP_CYCLES; i++) exp_q.push_back(ev(0, 0, 1, 0, 1));
    exp_q.push_back(ev(0, 0, 0, 1, 1));
    exp_q.push_back(ev(0, 0, 0, 0, 1));
    push_pulse(1'b0, 2'd0, 1'b0);
    exp_q.push_back(ev(0, 0, 0, 1, 0));
    exp_q.push_back(ev(0, 0, 0, 0, 0));
    for (int i = 0; i < exp_q.size(); i++) begin
      trig_q.push_back(i <= 1);
      en_q.push_back((i == 0) || (i >= 9));
    end
    n = 0;
    while (exp_q.size() > 0) begin
      tick(trig_q.pop_front(), en_q.pop_front());
      exp = exp_q.pop_front();
      got = {overflow, led, busy, done, pending};
      checks++;
      if (got !== exp) $display("FAIL enable_drop cyc %0d: got %b expected %b", n, got, exp);
      else passed++;
      n++;
    end
  endtask

  task automatic test_simultaneous();
    exp_q.push_back(ev(0, 1, 1, 0, 0));
    for (int i = 1; i < ON_CYCLES; i++) exp_q.push_back(ev(0, 1, 1, 0, 1));
    for (int i = 0; i < GAP_CYCLES; i++) exp_q.push_back(ev(0, 0, 1, 0, 1));
    push_pulse(1'b1, 2'd1, 1'b0);
    push_pulse(1'b1, 2'd0, 1'b0);
    exp_q.push_back(ev(0, 0, 0, 1, 0));
    exp_q.push_back(ev(0, 0, 0, 0, 0));
    for (int i = 0; i < exp_q.size(); i++) begin
      trig_q.push_back((i <= 1) || (i == ON_CYCLES + GAP_CYCLES));
      en_q.push_back(1'b1);
    end
    n = 0;
    while (exp_q.size() > 0) begin
      tick(trig_q.pop_front(), en_q.pop_front());
      exp = exp_q.pop_front();
      got = {overflow, led, busy, done, pending};
      checks++;
      if (got !== exp) $display("FAIL simultaneous cyc %0d: got %b expected %b", n, got, exp);
      else passed++;
      n++;
    end
  endtask

  task automatic test_async_reset_mid_pulse();
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    got = {overflow, led, busy, done, pending};
    checks++;
    if (got !== ev(0, 1, 1, 0, 1))
      $display("FAIL mid_pulse_pre: got %b expected %b", got, ev(0, 1, 1, 0, 1));
    else passed++;
    #2 reset = 1'b1;
    #1;
    got = {overflow, led, busy, done, pending};
    checks++;
    if (got !== 6'b0) $display("FAIL mid_pulse_reset: got %b expected %b", got, 6'b0);
    else passed++;
    #2 reset = 1'b0;
    for (int i = 0; i < ON_CYCLES + GAP_CYCLES + 3; i++) begin
      exp_q.push_back(ev(0, 0, 0, 0, 0));
      trig_q.push_back(1'b0);
      en_q.push_back(1'b1);
    end
    n = 0;
    while (exp_q.size() > 0) begin
      tick(trig_q.pop_front(), en_q.pop_front());
      exp = exp_q.pop_front();
      got = {overflow, led, busy, done, pending};
      checks++;
      if (got !== exp) $display("FAIL post_reset_idle cyc %0d: got %b expected %b", n, got, exp);
      else passed++;
      n++;
    end
  endtask

  // Sequence and final report
  initial begin
    checks  = 0;
    passed  = 0;
    trigger = 1'b0;
    enable  = 1'b0;
    reset   = 1'b0;
    test_reset();
    test_single_event();
    test_back_to_back();
    test_saturation();
    test_enable_gating();
    test_enable_drop();
    test_simultaneous();
    test_async_reset_mid_pulse();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Output-side counterpart to the input debouncer. It turns single-cycle internal event pulses, such as the debounced button pulse, into fixed-length pulses that a human can see on an LED or another slow external pin.
- Each pulse has a programmable high time followed by a mandatory low gap.
- Events that arrive while a pulse is in progress are queued in a saturating pending counter and replayed back-to-back.
- It sits between the control logic and the board LED or pin drivers.

Parameters:
- ON_CYCLES, 4095: clock cycles the output is held high per event. Range 1..2^CNT_W.
- GAP_CYCLES, 4095: clock cycles the output is held low after each high time. Range 1..2^CNT_W.
- CNT_W, 12: width of the internal duration counter.
- PEND_W, 4: width of the pending-event counter. It saturates at 2^PEND_W-1.

Ports:
- clock  input  1  system clock. All state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- trigger  input  1  single-cycle event request, sampled on the rising clock edge.
- enable  input  1  when low, no new pulse is started. Triggers are still queued.
- led  output  1  stretched pulse output, registered.
- busy  output  1  high while the FSM is not in IDLE, registered.
- pending  output  PEND_W  number of queued events not yet started.
- overflow  output  1  sticky flag: a trigger was lost because pending was saturated.
- done  output  1  one-cycle pulse after each GAP phase completes.

Behaviour:
- Reset, asynchronous:
  - FSM goes to IDLE and the counter goes to 0.
  - led=0, busy=0, pending=0, overflow=0, done=0.
  - Reset asserted mid-pulse kills the pulse immediately. No done is produced and queued events are discarded.
- States: IDLE, ON, GAP. led = (state==ON) and busy = (state!=IDLE), both taken directly from the registered state.
- IDLE transitions:
  - If enable=1 and (trigger=1 or pending>0): go to ON and load the counter with ON_CYCLES-1.
  - If that start was caused by pending>0: pending decrements.
  - If trigger and pending>0 occur together: the increment and decrement cancel and pending is unchanged.
  - If enable=0: stay in IDLE. A trigger increments pending (saturating).
- ON: the counter decrements each cycle. At counter==0, go to GAP and load GAP_CYCLES-1.
- GAP: the counter decrements each cycle. At counter==0:
  - done is registered high for the next cycle.
  - If enable=1 and pending>0 (or trigger=1), go directly to ON with no IDLE cycle and apply the pending update rule from IDLE.
  - Otherwise go to IDLE.
- Latency:
  - A trigger sampled at edge k in IDLE gives led=1 in the cycle after edge k.
  - led stays high exactly ON_CYCLES cycles, then low for at least GAP_CYCLES cycles.
  - busy is high for ON_CYCLES+GAP_CYCLES cycles per event.
- Triggers during ON or GAP (except the GAP final-cycle case above):
  - pending increments.
  - If pending==2^PEND_W-1, it holds and overflow is set to 1.
  - overflow clears only on reset.
- enable dropping during ON or GAP does not abort the current pulse. It only blocks the next start.
- Counter arithmetic is unsigned CNT_W bits. The counter never wraps, because it is reloaded before it would decrement below 0.
- pending arithmetic is unsigned PEND_W bits. It never underflows, because a decrement happens only when pending>0.

Test Plan (ON_CYCLES=4, GAP_CYCLES=3, PEND_W=2):
- Single event: one trigger pulse in IDLE, enable=1 → led high 4 cycles starting the next cycle, then low 3, done=1 for 1 cycle, busy high 7 cycles, pending stays 0.
- Back-to-back queue: 3 triggers during ON → pending=3, then 3 more pulses each 4 high/3 low with no IDLE gap, pending counts 2,1,0 at each GAP end, 4 done pulses total, overflow=0.
- Saturation: 5 triggers during a busy period → pending=3, overflow=1. After all replays pending=0 and overflow is still 1. Then reset → overflow=0.
- Enable gating: enable=0, trigger in IDLE → pending=1, led=0. Raise enable → led=1 the next cycle, pending=0.
- Simultaneous events: pending=1, trigger on the final GAP cycle → the next ON starts with no IDLE cycle, and pending stays 1.
- Async reset mid-pulse: assert reset in ON cycle 2 without a clock edge → led, busy, pending and done all go to 0 immediately. After release, the FSM is in IDLE and no done pulse appears.
